hazard_unit_p: RTL and testbench

Parametrised hazard controller for the five-stage fetch/decode/execute/memory/writeback pipeline. It adds three things the pipeline does not yet have:
- operand forwarding from the M and W stages into E;
- load-use stalling with a configurable number of bubble cycles, sequenced by an FSM;
- branch-taken flushing of D and E.

It sits beside the stage modules, consumes register addresses and control bits from D/E/M/W, and drives stall, flush and forward-select lines back into them. Optional saturating performance counters record stall and flush activity.

---
 rtl/hazard_unit_p.sv | 160 ++++++++++++++++
 tb/tb_hazard_unit_p.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_p.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_p
// Purpose  : Forwarding, load-use stall FSM and branch flush for the 5-stage
//            pipeline. Optional counters are built when HAZARD_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_p #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [2:0] HOLD_INIT = 3'(LOAD_STALL - 1);

  state_t     state_q, state_d;
  logic [2:0] hold_q, hold_d;
  logic       stall;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_m,
    input logic              we_w
  );
    // M is the younger producer, so it takes priority over W.
    if (we_m && (rd_m != '0) && (rd_m == rs))      fwd_sel = 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) fwd_sel = 2'b01;
    else                                           fwd_sel = 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
  end

  assign load_use = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stall   = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    if (PCSrcE) begin
      // A taken branch squashes everything, including a pending load-use stall.
      FlushD  = 1'b1;
      FlushE  = 1'b1;
      state_d = IDLE;
      hold_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use) begin
            stall  = 1'b1;
            FlushE = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = HOLD;
              hold_d  = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          stall  = 1'b1;
          FlushE = 1'b1;
          if (hold_q <= 3'd1) begin
            state_d = IDLE;
            hold_d  = 3'd0;
          end else begin
            hold_d = hold_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = 3'd0;
        end
      endcase
    end
  end

  assign StallF = stall;
  assign StallD = stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (PCSrcE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_cnt      = '0;
  assign flush_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_p.sv
`default_nettype none
// Bench for hazard_unit_p: three instances (LOAD_STALL 1/3/4, CNT_W 32/4/8)
// share one stimulus stream and are compared against a stall-budget model.
module tb_hazard_unit_p;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, cnt_clr;

  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic       sf [3];
  logic       sd [3];
  logic       fd [3];
  logic       fe [3];
  logic [31:0] sc1, fc1;
  logic [3:0]  sc3, fc3;
  logic [7:0]  sc4, fc4;

  int vectors = 0;
  int miscompares = 0;

  // Model state: remaining stall cycles owed after the current one.
  int     Ls [3]   = '{1, 3, 4};
  int     rem [3];
  longint sc_m [3];
  longint fc_m [3];
  longint maxv [3] = '{64'hFFFF_FFFF, 64'd15, 64'd255};

  always #5 clk = ~clk;

  hazard_unit_p #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]),
    .FlushD(fd[0]), .FlushE(fe[0]), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_unit_p #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]),
    .FlushD(fd[1]), .FlushE(fe[1]), .stall_cnt(sc3), .flush_cnt(fc3));

  hazard_unit_p #(.REG_AW(5), .LOAD_STALL(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
    .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(sf[2]), .StallD(sd[2]),
    .FlushD(fd[2]), .FlushE(fe[2]), .stall_cnt(sc4), .flush_cnt(fc4));

  wire [23:0] obs_ctl = {fa[0], fb[0], sf[0], sd[0], fd[0], fe[0],
                         fa[1], fb[1], sf[1], sd[1], fd[1], fe[1],
                         fa[2], fb[2], sf[2], sd[2], fd[2], fe[2]};
  wire [87:0] obs_cnt = {sc1, fc1, sc3, fc3, sc4, fc4};

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lu();
    return ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  function automatic bit m_stall(input int i);
    return !PCSrcE && (rem[i] > 0 || m_lu());
  endfunction

  function automatic logic [23:0] exp_ctl();
    logic [23:0] v;
    bit st;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      st = m_stall(i);
      v[23-8*i -: 8] = {m_fwd(Rs1E), m_fwd(Rs2E), st, st, PCSrcE, PCSrcE | st};
    end
    return v;
  endfunction

  function automatic logic [87:0] exp_cnt();
    return {32'(sc_m[0]), 32'(fc_m[0]), 4'(sc_m[1]), 4'(fc_m[1]),
            8'(sc_m[2]), 8'(fc_m[2])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0; sc_m[i] = 0; fc_m[i] = 0;
    end
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; cnt_clr = 0;
  endtask

  // Clock edge plus the model's view of what that edge does.
  task automatic advance();
    bit st [3];
    bit lu;
    lu = m_lu();
    for (int i = 0; i < 3; i++) st[i] = m_stall(i);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (PERF) begin
          if (cnt_clr) begin
            sc_m[i] = 0; fc_m[i] = 0;
          end else begin
            if (st[i] && sc_m[i] < maxv[i]) sc_m[i]++;
            if (PCSrcE && fc_m[i] < maxv[i]) fc_m[i]++;
          end
        end
        if (PCSrcE)         rem[i] = 0;
        else if (rem[i] > 0) rem[i]--;
        else if (lu)        rem[i] = Ls[i] - 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #2;
    vectors++;
    if (obs_ctl !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %h want %h", obs_ctl, 24'h0);
    end
    vectors++;
    if (obs_cnt !== 88'h0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %h want %h", obs_cnt, 88'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    advance();
  endtask

  task automatic test_forwarding();
    logic [1:0] want [3] = '{2'b10, 2'b01, 2'b00};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
      if (k >= 1) RegWriteM = 0;
      if (k == 2) begin RdW = 0; Rs1E = 0; Rs2E = 0; end
      @(negedge clk);
      vectors++;
      if (fa[0] !== want[k] || fb[2] !== want[k]) begin
        miscompares++;
        $display("FAIL fwd_plan%0d: got A=%b B=%b want %b", k, fa[0], fb[2], want[k]);
      end
      vectors++;
      if (obs_ctl !== exp_ctl()) begin
        miscompares++;
        $display("FAIL fwd_model%0d: got %h want %h", k, obs_ctl, exp_ctl());
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    int nst [3] = '{0, 0, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c == 0) begin ResultSrcE = 1; RdE = 7; Rs2D = 7; end
      @(negedge clk);
      for (int i = 0; i < 3; i++) nst[i] += int'(sf[i]);
      vectors++;
      if (obs_ctl !== exp_ctl()) begin
        miscompares++;
        $display("FAIL lu_cycle%0d: got %h want %h", c, obs_ctl, exp_ctl());
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (nst[i] != Ls[i]) begin
        miscompares++;
        $display("FAIL lu_len L=%0d: got %0d cycles want %0d", Ls[i], nst[i], Ls[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (obs_cnt !== {32'(PERF ? 1 : 0), 32'd0, 4'(PERF ? 3 : 0), 4'd0, 8'(PERF ? 4 : 0), 8'd0}) begin
      miscompares++;
      $display("FAIL lu_cnt: got %h want L-scaled stall counts", obs_cnt);
    end
    advance();
  endtask

  task automatic test_branch_vs_load();
    do_reset();
    idle_inputs();
    ResultSrcE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    @(negedge clk);
    vectors++;
    if (obs_ctl !== 24'h03_03_03) begin
      miscompares++;
      $display("FAIL br_lu: got %h want %h", obs_ctl, 24'h03_03_03);
    end
    advance();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (obs_ctl !== 24'h0) begin
      miscompares++;
      $display("FAIL br_after: got %h want %h", obs_ctl, 24'h0);
    end
    vectors++;
    if (obs_cnt !== {32'd0, 32'(PERF ? 1 : 0), 4'd0, 4'(PERF ? 1 : 0), 8'd0, 8'(PERF ? 1 : 0)}) begin
      miscompares++;
      $display("FAIL br_cnt: got %h want flush=1 stall=0", obs_cnt);
    end
    advance();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    idle_inputs();
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    advance();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (sf[2] !== 1'b1 || obs_ctl !== exp_ctl()) begin
      miscompares++;
      $display("FAIL hold_pre: got %h want %h", obs_ctl, exp_ctl());
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs_ctl !== 24'h0 || obs_cnt !== 88'h0) begin
      miscompares++;
      $display("FAIL hold_rst: got ctl=%h cnt=%h want 0", obs_ctl, obs_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    advance();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (obs_ctl !== 24'h0) begin
        miscompares++;
        $display("FAIL hold_release%0d: got %h want %h", c, obs_ctl, 24'h0);
      end
      advance();
    end
  endtask

  task automatic test_counters();
    do_reset();
    idle_inputs();
    ResultSrcE = 1; RdE = 9; Rs1D = 9;
    for (int c = 0; c < 20; c++) advance();
    @(negedge clk);
    vectors++;
    if (obs_cnt !== {32'(PERF ? 20 : 0), 32'd0, 4'(PERF ? 15 : 0), 4'd0, 8'(PERF ? 20 : 0), 8'd0}) begin
      miscompares++;
      $display("FAIL cnt_sat: got %h want stall=20/15/20", obs_cnt);
    end
    cnt_clr = 1;
    advance();
    cnt_clr = 0;
    @(negedge clk);
    vectors++;
    if (obs_cnt !== 88'h0) begin
      miscompares++;
      $display("FAIL cnt_clr: got %h want %h", obs_cnt, 88'h0);
    end
    idle_inputs();
    PCSrcE = 1;
    for (int c = 0; c < 18; c++) advance();
    PCSrcE = 0;
    @(negedge clk);
    vectors++;
    if (obs_cnt !== {32'd0, 32'(PERF ? 18 : 0), 4'd0, 4'(PERF ? 15 : 0), 8'd0, 8'(PERF ? 18 : 0)}) begin
      miscompares++;
      $display("FAIL cnt_flush_sat: got %h want flush=18/15/18", obs_cnt);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 7) == 0);
      cnt_clr    = ($urandom_range(0, 40) == 0);
      @(negedge clk);
      vectors++;
      if (obs_ctl !== exp_ctl()) begin
        miscompares++;
        $display("FAIL rand_ctl%0d: got %h want %h", c, obs_ctl, exp_ctl());
      end
      vectors++;
      if (obs_cnt !== exp_cnt()) begin
        miscompares++;
        $display("FAIL rand_cnt%0d: got %h want %h", c, obs_cnt, exp_cnt());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load();
    test_reset_mid_hold();
    test_counters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
